// File: rtl/turbo_rsc_encoder_pkg.sv
// Shared types and constants for the turbo RSC encoder: FSM states, RSC tap masks
// and the tap-parity helper used by both constituent encoders.
package turbo_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        TAIL1 = 3'd2,
        TAIL2 = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int         TAIL_LEN = 3;
    // Tap masks over the state vector {s0,s1,s2}
    localparam logic [2:0] G_FB     = 3'b011;
    localparam logic [2:0] G_FF     = 3'b101;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic tap_parity(input logic [2:0] st, input logic [2:0] taps);
        return ^(st & taps);
    endfunction

endpackage

// File: rtl/turbo_rsc_encoder_rsc_enc.sv
// 8-state recursive systematic convolutional encoder (fb 1+D^2+D^3, ff 1+D+D^3).
// In tail mode the input is replaced by the feedback so the register drains to zero.
module rsc_enc
    import turbo_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    input  logic       tail,
    input  logic       u,
    output logic       p,
    output logic       u_eff,
    output logic [2:0] state
);

    logic [2:0] state_r;
    logic       fb_s;
    logic       a_s;

    // Feedback, recursive bit and parity for the current input
    always_comb begin
        fb_s = tap_parity(state_r, G_FB);
        if (tail) begin
            u_eff = fb_s;
        end else begin
            u_eff = u;
        end
        a_s = u_eff ^ fb_s;
        p   = a_s ^ tap_parity(state_r, G_FF);
    end

    // Shift register {s0,s1,s2}, advancing only on an accepted step
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r <= 3'b000;
        end else if (clr) begin
            state_r <= 3'b000;
        end else if (en) begin
            state_r <= {a_s, state_r[2:1]};
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/turbo_rsc_encoder.sv
// Turbo encoder core: credit-based reads from the interleaver into a 2-entry skid FIFO,
// two parallel RSC encoders, then three termination steps per encoder.
module turbo_rsc_encoder
    import turbo_pkg::*;
#(
    parameter int BLK_LEN = 128,
    parameter int RD_LAT  = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start,
    output logic request,
    input  logic rdata,
    input  logic rdata_itl,
    input  logic out_rdy,
    output logic out_vld,
    output logic enc_sys,
    output logic enc_p1,
    output logic enc_p2,
    output logic enc_tail,
    output logic busy,
    output logic done
);

    localparam int             CNT_W     = cnt_width(BLK_LEN);
    localparam logic [CNT_W-1:0] BLK_N   = CNT_W'(BLK_LEN);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [1:0]     TAIL_LAST = 2'(TAIL_LEN - 1);

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  req_cnt_r;
    logic [CNT_W-1:0]  out_cnt_r;
    logic [1:0]        tail_cnt_r;
    logic [RD_LAT-1:0] inflight_r;
    logic [1:0][1:0]   fifo_r;
    logic [1:0][1:0]   fifo_s;
    logic [1:0]        fifo_cnt_r;
    logic [1:0]        fifo_cnt_s;
    logic [2:0]        pending_s;
    logic [1:0]        head_s;
    logic [1:0]        ret_s;
    logic              accept_s;
    logic              push_s;
    logic              data_xfer_s;
    logic              tail_xfer_s;
    logic              rsc1_en_s;
    logic              rsc2_en_s;
    logic              rsc1_tail_s;
    logic              rsc2_tail_s;
    logic              p1_s;
    logic              p2_s;
    logic              u1_s;
    logic              u2_s;
    logic [2:0]        rsc1_state_unused_s;
    logic [2:0]        rsc2_state_unused_s;

    // FSM next state, read credit and encoder step control
    always_comb begin
        state_s     = state_r;
        request     = 1'b0;
        out_vld     = 1'b0;
        enc_tail    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept_s    = 1'b0;
        data_xfer_s = 1'b0;
        tail_xfer_s = 1'b0;
        rsc1_en_s   = 1'b0;
        rsc2_en_s   = 1'b0;
        rsc1_tail_s = 1'b0;
        rsc2_tail_s = 1'b0;
        ret_s       = {rdata, rdata_itl};
        pending_s   = {1'b0, fifo_cnt_r} + 3'($countones(inflight_r));
        push_s      = (state_r == DATA) && inflight_r[RD_LAT-1];
        // An empty FIFO lets the returning bit pair straight through to the outputs
        if (fifo_cnt_r != 2'd0) begin
            head_s = fifo_r[0];
        end else begin
            head_s = ret_s;
        end
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = DATA;
                end else begin
                    state_s  = IDLE;
                end
            end
            DATA: begin
                busy        = 1'b1;
                request     = (req_cnt_r < BLK_N) && (pending_s < 3'd2);
                out_vld     = (fifo_cnt_r != 2'd0) || push_s;
                data_xfer_s = out_vld && out_rdy;
                rsc1_en_s   = data_xfer_s;
                rsc2_en_s   = data_xfer_s;
                if (data_xfer_s && (out_cnt_r == BLK_LAST)) begin
                    state_s = TAIL1;
                end else begin
                    state_s = DATA;
                end
            end
            TAIL1: begin
                busy        = 1'b1;
                out_vld     = 1'b1;
                enc_tail    = 1'b1;
                rsc1_tail_s = 1'b1;
                tail_xfer_s = out_rdy;
                rsc1_en_s   = out_rdy;
                if (out_rdy && (tail_cnt_r == TAIL_LAST)) begin
                    state_s = TAIL2;
                end else begin
                    state_s = TAIL1;
                end
            end
            TAIL2: begin
                busy        = 1'b1;
                out_vld     = 1'b1;
                enc_tail    = 1'b1;
                rsc2_tail_s = 1'b1;
                tail_xfer_s = out_rdy;
                rsc2_en_s   = out_rdy;
                if (out_rdy && (tail_cnt_r == TAIL_LAST)) begin
                    state_s = DONE;
                end else begin
                    state_s = TAIL2;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output mux: FIFO head and RSC parities in DATA, termination steps in the tail
    always_comb begin
        enc_sys = 1'b0;
        enc_p1  = 1'b0;
        enc_p2  = 1'b0;
        case (state_r)
            DATA: begin
                if (out_vld) begin
                    enc_sys = head_s[1];
                    enc_p1  = p1_s;
                    enc_p2  = p2_s;
                end else begin
                    enc_sys = 1'b0;
                end
            end
            TAIL1: begin
                enc_sys = u1_s;
                enc_p1  = p1_s;
            end
            TAIL2: begin
                enc_sys = u2_s;
                enc_p2  = p2_s;
            end
            default: begin
                enc_sys = 1'b0;
            end
        endcase
    end

    // Skid FIFO next state; a push into an empty FIFO that is consumed at once is not stored
    always_comb begin
        fifo_s     = fifo_r;
        fifo_cnt_s = fifo_cnt_r;
        case (fifo_cnt_r)
            2'd0: begin
                if (push_s && !data_xfer_s) begin
                    fifo_s[0]  = ret_s;
                    fifo_cnt_s = 2'd1;
                end else begin
                    fifo_cnt_s = 2'd0;
                end
            end
            2'd1: begin
                if (data_xfer_s && push_s) begin
                    fifo_s[0]  = ret_s;
                end else if (data_xfer_s) begin
                    fifo_cnt_s = 2'd0;
                end else if (push_s) begin
                    fifo_s[1]  = ret_s;
                    fifo_cnt_s = 2'd2;
                end else begin
                    fifo_cnt_s = 2'd1;
                end
            end
            2'd2: begin
                if (data_xfer_s) begin
                    fifo_s[0] = fifo_r[1];
                    if (push_s) begin
                        fifo_s[1] = ret_s;
                    end else begin
                        fifo_cnt_s = 2'd1;
                    end
                end else begin
                    fifo_cnt_s = 2'd2;
                end
            end
            default: begin
                fifo_cnt_s = 2'd0;
            end
        endcase
    end

    // State, counters, inflight tracker and FIFO storage
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r    <= IDLE;
            req_cnt_r  <= {CNT_W{1'b0}};
            out_cnt_r  <= {CNT_W{1'b0}};
            tail_cnt_r <= 2'd0;
            inflight_r <= {RD_LAT{1'b0}};
            fifo_r     <= 4'b0000;
            fifo_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            inflight_r <= RD_LAT'({inflight_r, request});
            fifo_r     <= fifo_s;
            fifo_cnt_r <= fifo_cnt_s;
            if (accept_s) begin
                req_cnt_r <= {CNT_W{1'b0}};
            end else if (request) begin
                req_cnt_r <= req_cnt_r + CNT_ONE;
            end else begin
                req_cnt_r <= req_cnt_r;
            end
            if (accept_s) begin
                out_cnt_r <= {CNT_W{1'b0}};
            end else if (data_xfer_s) begin
                out_cnt_r <= out_cnt_r + CNT_ONE;
            end else begin
                out_cnt_r <= out_cnt_r;
            end
            if (accept_s) begin
                tail_cnt_r <= 2'd0;
            end else if (tail_xfer_s) begin
                tail_cnt_r <= (tail_cnt_r == TAIL_LAST) ? 2'd0 : tail_cnt_r + 2'd1;
            end else begin
                tail_cnt_r <= tail_cnt_r;
            end
        end
    end

    rsc_enc u_rsc1 (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (accept_s),
        .en    (rsc1_en_s),
        .tail  (rsc1_tail_s),
        .u     (head_s[1]),
        .p     (p1_s),
        .u_eff (u1_s),
        .state (rsc1_state_unused_s)
    );

    rsc_enc u_rsc2 (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (accept_s),
        .en    (rsc2_en_s),
        .tail  (rsc2_tail_s),
        .u     (head_s[0]),
        .p     (p2_s),
        .u_eff (u2_s),
        .state (rsc2_state_unused_s)
    );

endmodule
